fifo_ptr_ctrl: RTL and testbench

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

---
 rtl/fifo_ptr_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Gray/binary pointer controller for one side of an async FIFO (write: full, read: empty).
// Define FIFO_PTR_LEVEL_EN to build the occupancy (level) and almost-full/empty logic.
module fifo_ptr_ctrl #(
   parameter int ADDR_WIDTH    = 4,
   parameter bit IS_WRITE      = 1'b1,
   parameter int ALMOST_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inc_req,
   input  logic [ADDR_WIDTH:0]   sync_gray,
   output logic                  inc_ack,
   output logic [ADDR_WIDTH:0]   bin_ptr,
   output logic [ADDR_WIDTH:0]   gray_ptr,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  flag,
   output logic                  almost,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  ovf_err
);

   localparam int P     = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic         inc;
   logic [P-1:0] bin_next;
   logic [P-1:0] gray_next;
   logic         flag_next;

   assign inc       = inc_req & ~flag;
   assign inc_ack   = inc;
   assign bin_next  = bin_ptr + {{(P-1){1'b0}}, inc};
   assign gray_next = (bin_next >> 1) ^ bin_next;
   assign addr      = bin_ptr[ADDR_WIDTH-1:0];

   // Full: remote pointer is exactly one lap behind, which in Gray means the top two bits differ.
   always_comb begin
      flag_next = 1'b0;
      if (IS_WRITE)
         flag_next = (gray_next == {~sync_gray[P-1:P-2], sync_gray[P-3:0]});
      else
         flag_next = (gray_next == sync_gray);
   end

   // NOTE: gray_ptr is encoded from bin_next, not bin_ptr, so it never lags the binary pointer by an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_ptr  <= '0;
         gray_ptr <= '0;
         flag     <= !IS_WRITE;
         ovf_err  <= 1'b0;
      end else begin
         bin_ptr  <= bin_next;
         gray_ptr <= gray_next;
         flag     <= flag_next;
         if (inc_req && flag)
            ovf_err <= 1'b1;
      end
   end

`ifdef FIFO_PTR_LEVEL_EN
   localparam logic [P-1:0] HI_MARK = P'(DEPTH - ALMOST_THRESH);
   localparam logic [P-1:0] LO_MARK = P'(ALMOST_THRESH);

   logic [P-1:0] remote_bin;
   logic [P-1:0] level_next;
   logic         almost_next;

   always_comb begin
      remote_bin = '0;
      for (int i = 0; i < P; i++)
         remote_bin[i] = ^(sync_gray >> i);
   end

   always_comb begin
      level_next  = '0;
      almost_next = 1'b0;
      if (IS_WRITE) begin
         level_next  = bin_next - remote_bin;
         almost_next = (level_next >= HI_MARK);
      end else begin
         level_next  = remote_bin - bin_next;
         almost_next = (level_next <= LO_MARK);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level  <= '0;
         almost <= !IS_WRITE;
      end else begin
         level  <= level_next;
         almost <= almost_next;
      end
   end
`else
   assign level  = '0;
   assign almost = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: one write-mode and one read-mode instance driven side by side.
module tb_fifo_ptr_ctrl;

   localparam int P = 5;
`ifdef FIFO_PTR_LEVEL_EN
   localparam bit LVL = 1'b1;
`else
   localparam bit LVL = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         w_rst_n, w_req, r_rst_n, r_req;
   logic [P-1:0] w_sg, r_sg;
   logic         w_ack, w_flag, w_almost, w_ovf, r_ack, r_flag, r_almost, r_ovf;
   logic [P-1:0] w_bin, w_gray, w_level, r_bin, r_gray, r_level;
   logic [3:0]   w_addr, r_addr;

   fifo_ptr_ctrl #(.ADDR_WIDTH(4), .IS_WRITE(1'b1), .ALMOST_THRESH(2)) dut_w (
      .clk(clk), .rst_n(w_rst_n), .inc_req(w_req), .sync_gray(w_sg), .inc_ack(w_ack),
      .bin_ptr(w_bin), .gray_ptr(w_gray), .addr(w_addr), .flag(w_flag), .almost(w_almost),
      .level(w_level), .ovf_err(w_ovf));

   fifo_ptr_ctrl #(.ADDR_WIDTH(4), .IS_WRITE(1'b0), .ALMOST_THRESH(2)) dut_r (
      .clk(clk), .rst_n(r_rst_n), .inc_req(r_req), .sync_gray(r_sg), .inc_ack(r_ack),
      .bin_ptr(r_bin), .gray_ptr(r_gray), .addr(r_addr), .flag(r_flag), .almost(r_almost),
      .level(r_level), .ovf_err(r_ovf));

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit ack_chk;
      bit ack;
      bit chk;
      int bin;
      bit flag;
      bit almost;
      int level;
      bit err;
   } exp_t;

   exp_t sbq_w[$];
   exp_t sbq_r[$];

   // Reference state: pointer as a plain count, occupancy as distance to the remote count.
   bit m_known[2];
   int m_bin[2];
   bit m_flag[2];
   bit m_err[2];
   bit m_alm[2];
   int m_lvl[2];

   function automatic logic [4:0] gray_of(input int x);
      int y;
      y = x & 31;
      return 5'(y ^ (y >> 1));
   endfunction

   function automatic int gray_decode(input logic [4:0] g);
      for (int r = 0; r < 32; r++)
         if (gray_of(r) == g) return r;
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input int k, input bit rst_n, input bit req, input logic [4:0] sg,
                             output exp_t e);
      bit wr;
      bit inc;
      int remote;
      int diff;
      wr        = (k == 0);
      e.ack_chk = m_known[k];
      e.ack     = req && !m_flag[k];
      if (!rst_n) begin
         m_known[k] = 1'b1;
         m_bin[k]   = 0;
         m_flag[k]  = !wr;
         m_err[k]   = 1'b0;
         m_lvl[k]   = 0;
         m_alm[k]   = LVL && !wr;
      end else if (m_known[k]) begin
         inc = req && !m_flag[k];
         if (req && m_flag[k]) m_err[k] = 1'b1;
         m_bin[k]  = (m_bin[k] + int'(inc)) % 32;
         remote    = gray_decode(sg);
         diff      = wr ? ((m_bin[k] - remote) & 31) : ((remote - m_bin[k]) & 31);
         m_flag[k] = wr ? (diff == 16) : (diff == 0);
         m_lvl[k]  = LVL ? diff : 0;
         m_alm[k]  = LVL && (wr ? (diff >= 14) : (diff <= 2));
      end
      e.chk    = m_known[k];
      e.bin    = m_bin[k];
      e.flag   = m_flag[k];
      e.err    = m_err[k];
      e.level  = m_lvl[k];
      e.almost = m_alm[k];
   endtask

   // Drive one clock's worth of inputs and queue what both instances must show after the next edge.
   task automatic cycle(input bit wr_rst, input bit wreq, input logic [4:0] wsg,
                        input bit rd_rst, input bit rreq, input logic [4:0] rsg);
      exp_t e;
      @(negedge clk);
      #1;
      w_rst_n = wr_rst; w_req = wreq; w_sg = wsg;
      r_rst_n = rd_rst; r_req = rreq; r_sg = rsg;
      model_step(0, wr_rst, wreq, wsg, e);
      sbq_w.push_back(e);
      model_step(1, rd_rst, rreq, rsg, e);
      sbq_r.push_back(e);
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic ack, input logic [4:0] bin,
                      input logic [4:0] gray, input logic [3:0] addr, input logic flag,
                      input logic almost, input logic [4:0] level, input logic ovf);
      if (e.ack_chk) check({tag, "_ack"}, ack, e.ack);
      if (e.chk) begin
         check({tag, "_bin"}, bin, e.bin);
         check({tag, "_gray"}, gray, gray_of(e.bin));
         check({tag, "_addr"}, addr, e.bin & 15);
         check({tag, "_flag"}, flag, e.flag);
         check({tag, "_almost"}, almost, e.almost);
         check({tag, "_level"}, level, e.level);
         check({tag, "_ovf"}, ovf, e.err);
      end
   endtask

   // Monitor: combinational ack sampled mid-low-phase, registered outputs just after the edge.
   initial begin
      logic a_w, a_r;
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         a_w = w_ack;
         a_r = r_ack;
         @(posedge clk);
         #1;
         if (sbq_w.size() > 0) begin
            e = sbq_w.pop_front();
            cmp("w", e, a_w, w_bin, w_gray, w_addr, w_flag, w_almost, w_level, w_ovf);
         end
         if (sbq_r.size() > 0) begin
            e = sbq_r.pop_front();
            cmp("r", e, a_r, r_bin, r_gray, r_addr, r_flag, r_almost, r_level, r_ovf);
         end
      end
   end

   initial begin
      int w_remote;
      int r_remote;
      bit wrst, rrst, wreq, rreq;
      logic [4:0] wsg, rsg;
      w_rst_n = 1'b0; w_req = 1'b0; w_sg = '0;
      r_rst_n = 1'b0; r_req = 1'b0; r_sg = '0;

      // Reset held two edges with requests pending
      repeat (2) cycle(1'b0, 1'b1, 5'h00, 1'b0, 1'b1, 5'h02);
      @(posedge clk); #1;
      check("rst_w_bin", w_bin, 5'h00);
      check("rst_w_gray", w_gray, 5'h00);
      check("rst_w_flag", w_flag, 1'b0);
      check("rst_w_level", w_level, 5'h00);
      check("rst_w_ovf", w_ovf, 1'b0);
      check("rst_r_flag", r_flag, 1'b1);
      check("rst_r_almost", r_almost, LVL);

      // Fill the write side; drain three entries on the read side meanwhile
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 1'b1, 5'h00, 1'b1, (i >= 1 && i <= 3), 5'h02);
      @(posedge clk); #1;
      check("fill_w_bin", w_bin, 5'h10);
      check("fill_w_gray", w_gray, 5'h18);
      check("fill_w_flag", w_flag, 1'b1);
      check("drain_r_bin", r_bin, 5'h03);
      check("drain_r_gray", r_gray, 5'h02);
      check("drain_r_flag", r_flag, 1'b1);
      check("drain_r_level", r_level, 5'h00);

      cycle(1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 5'h02);
      #1;
      check("push_full_ack", w_ack, 1'b0);
      @(posedge clk); #1;
      check("push_full_bin", w_bin, 5'h10);
      check("push_full_ovf", w_ovf, 1'b1);
      repeat (3) cycle(1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h02);
      @(posedge clk); #1;
      check("ovf_sticky", w_ovf, 1'b1);
      check("pop_empty_ovf", r_ovf, 1'b1);

      // Almost-full threshold
      cycle(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 5'h02);
      for (int i = 0; i < 13; i++)
         cycle(1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 5'h02);
      @(posedge clk); #1;
      check("alm13_level", w_level, LVL ? 5'd13 : 5'd0);
      check("alm13_almost", w_almost, 1'b0);
      cycle(1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 5'h02);
      @(posedge clk); #1;
      check("alm14_level", w_level, LVL ? 5'd14 : 5'd0);
      check("alm14_almost", w_almost, LVL);
      check("alm14_bin", w_bin, 5'd14);

      // Wrap: remote trails by one, so the write side never fills
      cycle(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 5'h00);
      for (int i = 0; i < 32; i++)
         cycle(1'b1, 1'b1, gray_of(m_bin[0] - 1), 1'b1, 1'($urandom_range(1)), 5'($urandom));
      @(posedge clk); #1;
      check("wrap_bin", w_bin, 5'h00);
      check("wrap_gray", w_gray, 5'h00);
      check("wrap_flag", w_flag, 1'b0);

      // Randomised traffic with a plausibly moving remote pointer
      cycle(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 5'h00);
      w_remote = 0;
      r_remote = 0;
      for (int i = 0; i < 600; i++) begin
         wrst = ($urandom_range(59) != 0);
         rrst = ($urandom_range(59) != 0);
         wreq = ($urandom_range(3) != 0);
         rreq = ($urandom_range(3) != 0);
         if (!wrst) w_remote = 0;
         else if ($urandom_range(1) == 1 && ((m_bin[0] - w_remote) & 31) != 0)
            w_remote = (w_remote + 1) % 32;
         if (!rrst) r_remote = 0;
         else if ($urandom_range(1) == 1 && ((r_remote - m_bin[1]) & 31) < 16)
            r_remote = (r_remote + 1) % 32;
         wsg = ($urandom_range(24) == 0) ? 5'($urandom) : gray_of(w_remote);
         rsg = ($urandom_range(24) == 0) ? 5'($urandom) : gray_of(r_remote);
         cycle(wrst, wreq, wsg, rrst, rreq, rsg);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
